// File: rtl/ticket_fifo_fwft.sv
// First-word-fall-through ticket FIFO on a simple dual-port RAM whose read register doubles as the head.
// Optional drop counter output is enabled by defining TICKET_FIFO_DROP_CNT_EN.
module ticket_fifo_fwft #(
  parameter int DATA_WIDTH     = 68,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  almost_full,
  output logic                  overflow
`ifdef TICKET_FIFO_DROP_CNT_EN
  , output logic [15:0]         drop_cnt
`endif
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt, usedw_nxt;
  logic                  wr_fire, rd_fire, drop, fetch;

  assign wr_ready = usedw < DEPTH_W;
  assign wr_fire  = wr_valid & wr_ready;
  assign drop     = wr_valid & ~wr_ready;
  assign rd_fire  = rd_valid & rd_ready;
  // Words still sitting in the RAM (not yet loaded into the head register).
  assign ram_cnt  = usedw - {{ADDR_WIDTH{1'b0}}, rd_valid};
  assign fetch    = (ram_cnt != '0) & (~rd_valid | rd_ready);

  always_comb begin
    usedw_nxt = usedw;
    if (wr_fire && !rd_fire)      usedw_nxt = usedw + CNT_ONE;
    else if (!wr_fire && rd_fire) usedw_nxt = usedw - CNT_ONE;
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem[wr_ptr] <= wr_data;
  end

  // Registered RAM read port, enabled only when the head slot is free or being popped.
  // A fetch never targets the slot being written on the same edge, since that would need a full RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
      rd_ptr <= '0;
    end else if (fetch) begin
      rd_data <= mem[rd_ptr];
      rd_valid <= 1'b1;
      rd_ptr <= rd_ptr + PTR_ONE;
    end else if (rd_fire) begin
      rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      usedw       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      usedw       <= usedw_nxt;
      almost_full <= usedw_nxt >= AF_TH;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef TICKET_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                        drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/ticket_fifo_fwft.md
TICKET_FIFO_FWFT -- requirements
Module: ticket_fifo_fwft

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 68, ticket word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving DEPTH = 2**ADDR_WIDTH stored entries.
REQ-003 The block SHALL have parameter ALMOST_FULL_TH, default 12, the almost_full assertion threshold (1..DEPTH).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 wr_data  in  DATA_WIDTH  ticket to enqueue.
REQ-008 wr_valid  in  1  write request.
REQ-009 wr_ready  out  1  space available; equals (usedw < DEPTH).
REQ-010 rd_data  out  DATA_WIDTH  head ticket, first-word-fall-through.
REQ-011 rd_valid  out  1  rd_data holds a valid head ticket.
REQ-012 rd_ready  in  1  consumer accepts the head ticket.
REQ-013 usedw  out  ADDR_WIDTH+1  entries accepted and not yet popped, range 0..DEPTH.
REQ-014 almost_full  out  1  registered flag, high when usedw >= ALMOST_FULL_TH.
REQ-015 overflow  out  1  sticky flag, a write was dropped.

Function
REQ-016 Storage SHALL be a simple dual-port RAM, DEPTH x DATA_WIDTH, with registered read (1-cycle latency) and old-data read-during-write.
REQ-017 A write SHALL be accepted on an edge where wr_valid & wr_ready; a read SHALL be accepted on an edge where rd_valid & rd_ready.
REQ-018 Write and read pointers SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0 without gaps.
REQ-019 usedw SHALL increment on an accepted write only, decrement on an accepted read only, and stay unchanged when both occur on the same edge.
REQ-020 A write accepted on edge E into an empty FIFO SHALL produce rd_valid=1 with that word on rd_data from edge E+2, not earlier.
REQ-021 rd_data SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-022 With rd_ready held high and a non-empty FIFO, the block SHALL sustain one read per cycle; with wr_valid held high and space available, one write per cycle.
REQ-023 Tickets SHALL exit in exact write order with no duplication or loss, including across pointer wrap.
REQ-024 At usedw=DEPTH, wr_ready SHALL be 0; a simultaneous accepted read SHALL raise wr_ready on the next edge.
REQ-025 wr_valid while wr_ready=0 SHALL drop the word, leave pointers and usedw unchanged, and set overflow on that edge.
REQ-026 almost_full SHALL update on the same edge as usedw.

Reset
REQ-027 On an edge with rst=1, the block SHALL set both pointers to 0, usedw=0, rd_valid=0, almost_full=0, overflow=0, rd_data=0; RAM contents are not cleared.
REQ-028 rst SHALL dominate any simultaneous handshake; in-flight and stored tickets are discarded, and the first write after reset is the first ticket read.
REQ-029 overflow SHALL clear only on reset.

Configuration
REQ-030 With macro TICKET_FIFO_DROP_CNT_EN defined, the block SHALL add output drop_cnt (16 bits), counting dropped writes per REQ-025, saturating at 16'hFFFF and cleared by rst.
REQ-031 Without TICKET_FIFO_DROP_CNT_EN, drop_cnt and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset, then write 0xA1 at edge E with rd_ready=0 -> rd_valid=0 at E+1, rd_valid=1 with rd_data=0xA1 at E+2, usedw=1 from E+1.
REQ-033 Fill 16 words 0..15 with rd_ready=0 -> wr_ready=0, usedw=16, almost_full=1 after the 12th write; a 17th write sets overflow and drop_cnt=1 (macro on), and 0..15 read back in order.
REQ-034 Stream 40 sequential words with wr_valid and rd_ready held high -> output sequence 0..39 with no gaps after the first two cycles, usedw never exceeds 2, pointers wrap twice.
REQ-035 At usedw=16, assert a write and a read on the same edge -> write dropped and overflow set; next edge usedw=15 and wr_ready=1.
REQ-036 Assert rst mid-stream with usedw=7 -> next edge usedw=0, rd_valid=0, overflow=0; a subsequent write of 0x55 is the first word read.
